// File: rtl/load_store_unit.sv
// Load/store unit: turns decoder load/store requests into single-beat bus
// transactions with byte-lane steering, sign/zero extension and misalignment detection.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        mem_ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        ctrl_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg, rdata_next;

    logic        load_req, store_req, valid_req;
    logic        half_req, word_req, misaligned_req;
    logic        accept, capture, is_store;
    logic [1:0]  off;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane, shifted;

    // A write request takes priority; a write with a load encoding is dropped.
    assign store_req = mem_wr && (mem_ctrl >= 3'd5);
    assign load_req  = !mem_wr && mem_rd && (mem_ctrl <= 3'd4);
    assign valid_req = load_req || store_req;

    assign half_req = (mem_ctrl == 3'b001) || (mem_ctrl == 3'b100) || (mem_ctrl == 3'b110);
    assign word_req = (mem_ctrl == 3'b010) || (mem_ctrl == 3'b111);
    assign misaligned_req = (half_req && addr[0]) || (word_req && (addr[1:0] != 2'b00));

    assign off      = addr_reg[1:0];
    assign is_store = (ctrl_reg >= 3'd5);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_req) begin
                    if (misaligned_req) begin
                        misalign = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_gnt) begin
                    if (is_store) begin
                        state_next = DONE;
                    end else if (bus_rvalid) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            stall    = 1'b0;
            misalign = 1'b0;
            accept   = 1'b0;
            capture  = 1'b0;
        end
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = bus_rdata >> {off, 3'b000};

    always_comb begin
        rdata_next = shifted;
        case (ctrl_reg)
            3'b000:  rdata_next = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  rdata_next = {{16{shifted[15]}}, shifted[15:0]};
            3'b011:  rdata_next = {24'h0, shifted[7:0]};
            3'b100:  rdata_next = {16'h0, shifted[15:0]};
            default: rdata_next = shifted;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic LANE_HI = (gi >= 2);
            localparam int   LANE_LO = gi % 2;
            assign be_lane[gi] = (ctrl_reg == 3'b101) ? (off == 2'(gi)) :
                                 (ctrl_reg == 3'b110) ? (off[1] == LANE_HI) : 1'b1;
            assign wdata_lane[8*gi +: 8] = (ctrl_reg == 3'b101) ? wdata_reg[7:0] :
                                           (ctrl_reg == 3'b110) ? wdata_reg[8*LANE_LO +: 8] :
                                                                  wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign bus_req   = (state_reg == REQ);
    assign bus_we    = bus_req && is_store;
    assign bus_addr  = bus_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be    = bus_req ? (is_store ? be_lane : 4'hF) : 4'h0;
    assign bus_wdata = bus_we ? wdata_lane : 32'h0;
    assign rdata     = rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            ctrl_reg  <= 3'b000;
            wdata_reg <= 32'h0;
            rdata_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= addr;
                ctrl_reg  <= mem_ctrl;
                wdata_reg <= wdata;
            end
            if (capture) begin
                rdata_reg <= rdata_next;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_load_store_unit;
    localparam int AW = 32;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst, mem_rd, mem_wr;
    logic [2:0]    mem_ctrl;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;
    logic          stall, misalign, bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_gnt, bus_rvalid;
    logic [31:0]   bus_rdata;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which phase of a transaction we are in, plus the captured request.
    int          m_phase = P_IDLE;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;
    logic [2:0]  m_ctrl = 3'b000;

    int          n_stall, n_req;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [2:0] c);
        case (c)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    // 0 = nothing, 1 = load, 2 = store
    function automatic int req_kind();
        if (mem_wr) return (mem_ctrl >= 3'd5) ? 2 : 0;
        if (mem_rd) return (mem_ctrl <= 3'd4) ? 1 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] c, input logic [1:0] o,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * int'(o));
        case (c)
            3'd0:    return 32'($signed(s[7:0]));
            3'd1:    return 32'($signed(s[15:0]));
            3'd3:    return 32'(s[7:0]);
            3'd4:    return 32'(s[15:0]);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] c, input logic [1:0] o);
        if (c == 3'd5) return 4'(1 << o);
        if (c == 3'd6) return o[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] c, input logic [31:0] w);
        if (c == 3'd5) return {24'h0, w[7:0]} * 32'h01010101;
        if (c == 3'd6) return {16'h0, w[15:0]} * 32'h00010001;
        return w;
    endfunction

    task automatic model_check();
        int   k;
        bit   aligned, in_req, st;
        k       = req_kind();
        aligned = (int'(addr[1:0]) % acc_size(mem_ctrl)) == 0;
        in_req  = (m_phase == P_REQ);
        st      = (m_ctrl >= 3'd5);
        chk("stall", 32'(stall), 32'(!rst && (m_phase == P_REQ || m_phase == P_WAIT ||
                                    (m_phase == P_IDLE && k != 0 && aligned))));
        chk("misalign", 32'(misalign), 32'(!rst && m_phase == P_IDLE && k != 0 && !aligned));
        chk("bus_req", 32'(bus_req), 32'(in_req));
        chk("bus_we", 32'(bus_we), 32'(in_req && st));
        chk("bus_addr", bus_addr, in_req ? (m_addr & ~32'h3) : 32'h0);
        chk("bus_be", 32'(bus_be), in_req ? 32'(st ? store_be(m_ctrl, m_addr[1:0]) : 4'hF) : 32'h0);
        chk("bus_wdata", bus_wdata, (in_req && st) ? store_data(m_ctrl, m_wdata) : 32'h0);
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic model_update();
        if (rst) begin
            m_phase = P_IDLE;
            m_rdata = 32'h0;
        end else begin
            case (m_phase)
                P_IDLE: if (req_kind() != 0 && (int'(addr[1:0]) % acc_size(mem_ctrl)) == 0) begin
                    m_addr = addr; m_ctrl = mem_ctrl; m_wdata = wdata; m_phase = P_REQ;
                end
                P_REQ: if (bus_gnt) begin
                    if (m_ctrl >= 3'd5) m_phase = P_DONE;
                    else if (bus_rvalid) begin
                        m_rdata = load_value(m_ctrl, m_addr[1:0], bus_rdata);
                        m_phase = P_DONE;
                    end else m_phase = P_WAIT;
                end
                P_WAIT: if (bus_rvalid) begin
                    m_rdata = load_value(m_ctrl, m_addr[1:0], bus_rdata);
                    m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic clear_inputs();
        mem_rd = 1'b0; mem_wr = 1'b0; mem_ctrl = 3'b000; addr = '0; wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Runs one access from IDLE and returns with the DUT settled in its DONE cycle.
    task automatic access(input logic rd_i, input logic wr_i, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] word);
        clear_inputs();
        mem_rd = rd_i; mem_wr = wr_i; mem_ctrl = c; addr = a; wdata = wd;
        n_stall = 0; n_req = 0;
        settle();
        if (stall) n_stall++;
        tick();
        clear_inputs();
        for (int i = 0; i <= gnt_dly; i++) begin
            bus_gnt = (i == gnt_dly); bus_rvalid = (i == gnt_dly) && (rv_dly == 0); bus_rdata = word;
            settle();
            if (stall) n_stall++;
            if (bus_req) n_req++;
            if (i == 0) begin
                s_we = bus_we; s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata;
            end else begin
                chk("req_hold_addr", bus_addr, s_addr);
                chk("req_hold_be", 32'(bus_be), 32'(s_be));
                chk("req_hold_wdata", bus_wdata, s_wdata);
                chk("req_hold_we", 32'(bus_we), 32'(s_we));
            end
            tick();
        end
        clear_inputs();
        for (int i = 1; i <= rv_dly; i++) begin
            bus_rvalid = (i == rv_dly); bus_rdata = word;
            settle();
            if (stall) n_stall++;
            tick();
        end
        clear_inputs();
        settle();
        $display("txn ctrl=%0d addr=0x%08h stall_cycles=%0d req_cycles=%0d rdata=0x%08h",
                 c, a, n_stall, n_req, rdata);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        settle();
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_bus_req", 32'(bus_req), 32'h0);
        tick();
        rst = 1'b0;

        access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
        chk("lw_bus_addr", s_addr, 32'h100);
        chk("lw_bus_be", 32'(s_be), 32'hF);
        chk("lw_stall_cycles", n_stall, 3);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        tick();

        access(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 0, 1, 32'h80FFFF7F);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        tick();
        access(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 0, 1, 32'h80FFFF7F);
        chk("lbu_rdata", rdata, 32'h00000080);
        tick();

        access(1'b0, 1'b1, 3'd6, 32'h202, 32'h1234ABCD, 3, 0, 32'h0);
        chk("sh_bus_addr", s_addr, 32'h200);
        chk("sh_bus_be", 32'(s_be), 32'hC);
        chk("sh_bus_wdata", s_wdata, 32'hABCDABCD);
        chk("sh_bus_we", 32'(s_we), 32'h1);
        chk("sh_req_cycles", n_req, 4);
        chk("sh_done_stall", 32'(stall), 32'h0);
        chk("sh_rdata_kept", rdata, 32'h00000080);
        tick();

        clear_inputs();
        mem_rd = 1'b1; mem_ctrl = 3'd2; addr = 32'h101;
        settle();
        chk("mis_pulse", 32'(misalign), 32'h1);
        chk("mis_stall", 32'(stall), 32'h0);
        chk("mis_bus_req", 32'(bus_req), 32'h0);
        tick();
        clear_inputs();
        settle();
        chk("mis_after_req", 32'(bus_req), 32'h0);
        chk("mis_after_pulse", 32'(misalign), 32'h0);
        chk("mis_rdata_kept", rdata, 32'h00000080);
        tick();

        access(1'b1, 1'b0, 3'd4, 32'h002, 32'h0, 0, 0, 32'h80010000);
        chk("lhu_stall_cycles", n_stall, 2);
        chk("lhu_rdata", rdata, 32'h00008001);
        tick();

        clear_inputs();
        mem_rd = 1'b1; mem_ctrl = 3'd2; addr = 32'h100;
        settle(); tick();
        clear_inputs(); bus_gnt = 1'b1;
        settle(); tick();
        clear_inputs(); rst = 1'b1;
        settle(); tick();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
        settle();
        chk("rstw_bus_req", 32'(bus_req), 32'h0);
        chk("rstw_stall", 32'(stall), 32'h0);
        chk("rstw_bus_addr", bus_addr, 32'h0);
        chk("rstw_bus_be", 32'(bus_be), 32'h0);
        chk("rstw_rdata", rdata, 32'h0);
        tick();
        clear_inputs();
        settle();
        chk("rstw_late_rvalid", rdata, 32'h0);
        tick();

        rst = 1'b1;
        settle(); tick();
        rst = 1'b0; mem_rd = 1'b1; mem_ctrl = 3'd2; addr = 32'h40;
        settle();
        chk("post_rst_accept", 32'(stall), 32'h1);
        tick();
        clear_inputs(); bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
        settle();
        chk("post_rst_bus_req", 32'(bus_req), 32'h1);
        chk("post_rst_bus_addr", bus_addr, 32'h40);
        tick();
        clear_inputs();
        settle();
        chk("post_rst_rdata", rdata, 32'h0BADF00D);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 63) == 0);
            mem_rd     = 1'($urandom_range(0, 1));
            mem_wr     = ($urandom_range(0, 2) == 0);
            mem_ctrl   = 3'($urandom_range(0, 7));
            addr       = $urandom;
            wdata      = $urandom;
            bus_gnt    = 1'($urandom_range(0, 1));
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
